snoop_bcast: RTL and testbench

SNOOP_BCAST -- requirements
Module: snoop_bcast

---
 rtl/snoop_bcast_pkg.sv | 43 ++++
 rtl/snoop_bcast_if.sv | 20 ++
 rtl/snoop_bcast_lzc.sv | 24 ++
 rtl/snoop_bcast.sv | 142 ++++++++++++++
 tb/tb_snoop_bcast.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snoop_bcast_pkg.sv
// Shared ACE snoop definitions: channel bundles, CR response bit positions and
// the broadcaster FSM states.
package ace_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ace_ac_chan_t;

  typedef logic [4:0] ace_cr_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } ace_cd_chan_t;

  typedef struct packed {
    ace_ac_chan_t ac;
    logic         ac_valid;
    logic         cr_ready;
    logic         cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic         ac_ready;
    logic         cr_valid;
    ace_cr_chan_t cr_resp;
    logic         cd_valid;
    ace_cd_chan_t cd;
  } ace_snoop_resp_t;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  typedef enum logic [2:0] {
    IDLE, BCAST, COLLECT, RESP, DATA
  } snoop_state_e;

endpackage

// File: rtl/snoop_bcast_if.sv
// Bundle of the broadcaster's upstream and per-cache snoop channels.
interface snoop_bcast_if
  import ace_pkg::*;
#(
  parameter int unsigned NoMstPorts   = 2,
  parameter type         snoop_req_t  = ace_snoop_req_t,
  parameter type         snoop_resp_t = ace_snoop_resp_t
) ();

  snoop_req_t                   slv_req;
  snoop_resp_t                  slv_resp;
  logic [NoMstPorts-1:0]        slv_mask;
  snoop_req_t  [NoMstPorts-1:0] mst_reqs;
  snoop_resp_t [NoMstPorts-1:0] mst_resps;

  // master: initiator plus cache side environment; slave: the broadcaster
  modport master (output slv_req, slv_mask, mst_resps, input slv_resp, mst_reqs);
  modport slave  (input slv_req, slv_mask, mst_resps, output slv_resp, mst_reqs);

endinterface

// File: rtl/snoop_bcast_lzc.sv
// Leading/trailing zero counter; MODE=0 returns the index of the lowest set bit.
module lzc #(
  parameter  int unsigned WIDTH = 2,
  parameter  bit          MODE  = 1'b0,
  localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  // scan downwards so the smallest count wins
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[MODE ? (WIDTH - 1 - i) : i]) begin
        cnt_o   = CntW'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/snoop_bcast.sv
// ACE snoop broadcaster: fans one AC out to a set of caches, OR-merges their
// CR responses and forwards the data of the lowest-index supplier.
module snoop_bcast
  import ace_pkg::*;
#(
  parameter int unsigned NoMstPorts   = 2,
  parameter type         snoop_req_t  = ace_snoop_req_t,
  parameter type         snoop_resp_t = ace_snoop_resp_t,
  parameter type         ac_chan_t    = ace_ac_chan_t,
  parameter type         cr_chan_t    = ace_cr_chan_t,
  parameter type         cd_chan_t    = ace_cd_chan_t
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  snoop_req_t                   slv_req_i,
  output snoop_resp_t                  slv_resp_o,
  input  logic [NoMstPorts-1:0]        slv_mask_i,
  output snoop_req_t  [NoMstPorts-1:0] mst_reqs_o,
  input  snoop_resp_t [NoMstPorts-1:0] mst_resps_i
);

  localparam int unsigned IdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  snoop_state_e          state_q, state_d;
  ac_chan_t              ac_q;
  cr_chan_t              crresp_q, cr_merge;
  cd_chan_t              win_cd;
  logic [NoMstPorts-1:0] tgt_q, ac_done_q, cr_done_q, dt_q, cd_done_q;
  logic [NoMstPorts-1:0] ac_hs, cr_hs, cr_dt, cd_last_hs;
  logic [IdxW-1:0]       win_q, win_idx;
  logic                  win_none, slv_ac_hs;

  assign slv_ac_hs = slv_resp_o.ac_ready & slv_req_i.ac_valid;

  for (genvar i = 0; i < NoMstPorts; i++) begin : g_port
    assign ac_hs[i]      = mst_reqs_o[i].ac_valid & mst_resps_i[i].ac_ready;
    assign cr_hs[i]      = mst_reqs_o[i].cr_ready & mst_resps_i[i].cr_valid;
    assign cr_dt[i]      = mst_resps_i[i].cr_resp[CrDataTransfer];
    assign cd_last_hs[i] = mst_reqs_o[i].cd_ready & mst_resps_i[i].cd_valid
                         & mst_resps_i[i].cd.last;
  end

  always_comb begin
    cr_merge = crresp_q;
    for (int i = 0; i < NoMstPorts; i++)
      if (cr_hs[i]) cr_merge = cr_merge | mst_resps_i[i].cr_resp;
  end

  lzc #(.WIDTH(NoMstPorts), .MODE(1'b0)) i_win_lzc (
    .in_i    (dt_q),
    .cnt_o   (win_idx),
    .empty_o (win_none)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (slv_ac_hs) state_d = (slv_mask_i != '0) ? BCAST : RESP;
      BCAST:   if (ac_done_q == tgt_q) state_d = COLLECT;
      COLLECT: if (cr_done_q == tgt_q) state_d = RESP;
      RESP:    if (slv_req_i.cr_ready) state_d = crresp_q[CrDataTransfer] ? DATA : IDLE;
      DATA:    if ((cd_done_q | cd_last_hs) == dt_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs; everything is held quiet while reset is asserted
  assign win_cd = mst_resps_i[win_q].cd;

  always_comb begin
    slv_resp_o = '0;
    mst_reqs_o = '0;
    for (int i = 0; i < NoMstPorts; i++) mst_reqs_o[i].ac = ac_q;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: slv_resp_o.ac_ready = 1'b1;
        BCAST, COLLECT: begin
          for (int i = 0; i < NoMstPorts; i++) begin
            mst_reqs_o[i].ac_valid = (state_q == BCAST) & tgt_q[i] & ~ac_done_q[i];
            mst_reqs_o[i].cr_ready = tgt_q[i] & ac_done_q[i] & ~cr_done_q[i];
          end
        end
        RESP: begin
          slv_resp_o.cr_valid = 1'b1;
          slv_resp_o.cr_resp  = crresp_q;
        end
        DATA: begin
          slv_resp_o.cd       = win_cd;
          slv_resp_o.cd_valid = mst_resps_i[win_q].cd_valid & ~cd_done_q[win_q];
          // the winner follows upstream backpressure, other suppliers are drained
          for (int i = 0; i < NoMstPorts; i++)
            if (dt_q[i] && !cd_done_q[i])
              mst_reqs_o[i].cd_ready = (IdxW'(i) == win_q) ? slv_req_i.cd_ready : 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ac_q      <= '0;
      tgt_q     <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      dt_q      <= '0;
      crresp_q  <= '0;
      cd_done_q <= '0;
      win_q     <= '0;
    end else if (slv_ac_hs) begin
      ac_q      <= slv_req_i.ac;
      tgt_q     <= slv_mask_i;
      ac_done_q <= '0;
      cr_done_q <= '0;
      dt_q      <= '0;
      crresp_q  <= '0;
      cd_done_q <= '0;
    end else begin
      ac_done_q <= ac_done_q | ac_hs;
      cr_done_q <= cr_done_q | cr_hs;
      dt_q      <= dt_q | (cr_hs & cr_dt);
      crresp_q  <= cr_merge;
      cd_done_q <= cd_done_q | cd_last_hs;
      if (state_q == RESP && slv_req_i.cr_ready && !win_none) win_q <= win_idx;
    end
  end

  logic [31:0] mask_ext;
  assign mask_ext = 32'(slv_mask_i);

  a_mask_range: assert property (@(posedge clk_i) disable iff (rst_i)
    (mask_ext >> NoMstPorts) == 32'd0)
    else $error("snoop_bcast: slv_mask_i targets a nonexistent port");

endmodule

// File: tb/tb_snoop_bcast.sv
// Directed bench for snoop_bcast with a two-port reactive cache model.
module tb_snoop_bcast;
  import ace_pkg::*;

  logic clk, rst_i;
  int   n_tests = 0, n_fail = 0;

  snoop_bcast_if #(.NoMstPorts(2)) bus ();

  snoop_bcast #(.NoMstPorts(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .slv_req_i   (bus.slv_req),
    .slv_resp_o  (bus.slv_resp),
    .slv_mask_i  (bus.slv_mask),
    .mst_reqs_o  (bus.mst_reqs),
    .mst_resps_i (bus.mst_resps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [7:0] ctl;
  always_comb begin
    ctl = '0;
    ctl = {bus.mst_reqs[1].ac_valid, bus.mst_reqs[0].ac_valid,
           bus.mst_reqs[1].cr_ready, bus.mst_reqs[0].cr_ready,
           bus.mst_reqs[1].cd_ready, bus.mst_reqs[0].cd_ready,
           bus.slv_resp.cr_valid,    bus.slv_resp.cd_valid};
  end

  // cache model configuration (main thread) and state (model thread)
  int          ac_stall[2], cr_dly[2], nbeats[2];
  logic [4:0]  cr_val[2];
  logic [31:0] dbase[2];
  int          arm_seq = 0;
  logic [31:0] exp_addr = '0;
  int          ph[2], acv_cnt[2];
  logic [31:0] cd_got[8];

  initial begin : cache_model
    int cnt[2], beat[2], stall[2], seen_seq;
    bit pend[2], s_acv[2], s_ac_hs[2], s_cr_hs[2], s_cd_hs[2];
    seen_seq = 0;
    for (int p = 0; p < 2; p++) begin
      ph[p] = 0; cnt[p] = 0; beat[p] = 0; stall[p] = 0; pend[p] = 0; acv_cnt[p] = 0;
    end
    bus.mst_resps = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        s_acv[p]   = bus.mst_reqs[p].ac_valid;
        s_ac_hs[p] = s_acv[p] && bus.mst_resps[p].ac_ready;
        s_cr_hs[p] = bus.mst_reqs[p].cr_ready && bus.mst_resps[p].cr_valid;
        s_cd_hs[p] = bus.mst_reqs[p].cd_ready && bus.mst_resps[p].cd_valid;
        if (pend[p]) chk($sformatf("ac_hold%0d", p), 32'(s_acv[p]), 32'd1);
        if (s_acv[p]) begin
          chk($sformatf("ac_addr%0d", p), bus.mst_reqs[p].ac.addr, exp_addr);
          acv_cnt[p]++;
        end
        pend[p] = s_acv[p] && !s_ac_hs[p];
      end
      @(posedge clk); #2;
      if (seen_seq != arm_seq) begin
        seen_seq = arm_seq;
        for (int p = 0; p < 2; p++) begin
          ph[p] = 0; cnt[p] = 0; beat[p] = 0; stall[p] = 0; pend[p] = 0;
        end
        bus.mst_resps = '0;
        continue;
      end
      for (int p = 0; p < 2; p++) begin
        if (ph[p] == 0) begin
          if (s_ac_hs[p]) begin ph[p] = 1; cnt[p] = 0; end
          else if (s_acv[p]) stall[p]++;
        end
        if (ph[p] == 1) begin
          if (cnt[p] >= cr_dly[p]) ph[p] = 2;
          else cnt[p]++;
        end
        if (ph[p] == 2 && s_cr_hs[p]) begin
          ph[p] = (nbeats[p] > 0) ? 3 : 4;
          beat[p] = 0;
        end
        if (ph[p] == 3 && s_cd_hs[p]) begin
          if (beat[p] == nbeats[p] - 1) ph[p] = 4;
          beat[p]++;
        end
        bus.mst_resps[p].ac_ready = (ph[p] == 0) && (stall[p] >= ac_stall[p]);
        bus.mst_resps[p].cr_valid = (ph[p] == 2);
        bus.mst_resps[p].cr_resp  = cr_val[p];
        bus.mst_resps[p].cd_valid = (ph[p] == 3);
        bus.mst_resps[p].cd.data  = dbase[p] + 32'(beat[p]);
        bus.mst_resps[p].cd.last  = (beat[p] == nbeats[p] - 1);
      end
    end
  end

  task automatic arm(input int st0, input int st1, input int d0, input int d1,
                     input logic [4:0] c0, input logic [4:0] c1,
                     input int nb0, input int nb1, input logic [31:0] b0, input logic [31:0] b1);
    ac_stall[0] = st0; ac_stall[1] = st1; cr_dly[0] = d0; cr_dly[1] = d1;
    cr_val[0] = c0; cr_val[1] = c1; nbeats[0] = nb0; nbeats[1] = nb1;
    dbase[0] = b0; dbase[1] = b1;
    arm_seq++;
  endtask

  task automatic snoop(input logic [31:0] addr, input logic [1:0] mask);
    bit ok = 0;
    exp_addr = addr;
    bus.slv_req.ac       = '0;
    bus.slv_req.ac.addr  = addr;
    bus.slv_req.ac_valid = 1'b1;
    bus.slv_mask         = mask;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = bus.slv_resp.ac_ready;
      @(posedge clk); #1;
    end
    bus.slv_req.ac_valid = 1'b0;
    bus.slv_mask         = '0;
    chk("ac_accept", 32'(ok), 32'd1);
  endtask

  task automatic get_cr(output logic [4:0] r);
    bit ok = 0;
    r = '0;
    bus.slv_req.cr_ready = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (bus.slv_resp.cr_valid) begin ok = 1; r = bus.slv_resp.cr_resp; end
      @(posedge clk); #1;
    end
    bus.slv_req.cr_ready = 1'b0;
    chk("cr_seen", 32'(ok), 32'd1);
  endtask

  task automatic get_cd(input int maxb, output int n, output int lp);
    n = 0; lp = -1;
    bus.slv_req.cd_ready = 1'b1;
    for (int c = 0; c < 100 && n < maxb && lp < 0; c++) begin
      @(negedge clk);
      if (bus.slv_resp.cd_valid) begin
        cd_got[n] = bus.slv_resp.cd.data;
        if (bus.slv_resp.cd.last) lp = n;
        n++;
      end
      @(posedge clk); #1;
    end
    bus.slv_req.cd_ready = 1'b0;
    chk("cd_seen", 32'(lp >= 0 || n == maxb), 32'd1);
  endtask

  task automatic wait_idle(output int leaks);
    bit ok = 0;
    leaks = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = bus.slv_resp.ac_ready;
      if (bus.slv_resp.cd_valid) leaks++;
      @(posedge clk); #1;
    end
    chk("idle_seen", 32'(ok), 32'd1);
  endtask

  initial begin : main
    logic [4:0] r;
    int n, lp, a0, leaks;
    rst_i = 1'b1;
    bus.slv_req = '0;
    bus.slv_mask = '0;
    arm(0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_ac_ready", 32'(bus.slv_resp.ac_ready), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("idle_ac_ready", 32'(bus.slv_resp.ac_ready), 32'd1);
    chk("idle_ctl", 32'(ctl), 32'd0);
    @(posedge clk); #1;

    // both caches miss: single zero CR, no data, IDLE right after the CR handshake
    arm(0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    snoop(32'h0000_1000, 2'b11);
    get_cr(r);
    chk("s1_cr", 32'(r), 32'd0);
    @(negedge clk);
    chk("s1_ac_ready", 32'(bus.slv_resp.ac_ready), 32'd1);
    chk("s1_no_cd", 32'(bus.slv_resp.cd_valid), 32'd0);
    @(posedge clk); #1;

    // empty mask: CR=0 in the cycle after accept, no downstream AC
    arm(0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
    a0 = acv_cnt[0] + acv_cnt[1];
    snoop(32'h0000_2000, 2'b00);
    @(negedge clk);
    chk("s2_cr_valid", 32'(bus.slv_resp.cr_valid), 32'd1);
    chk("s2_cr_val", 32'(bus.slv_resp.cr_resp), 32'd0);
    @(posedge clk); #1;
    get_cr(r);
    chk("s2_no_ac", 32'(acv_cnt[0] + acv_cnt[1]), 32'(a0));

    // out-of-order CR merge, port1 supplies 4 beats
    arm(0, 0, 3, 0, 5'b00100, 5'b01001, 0, 4, 32'h0, 32'h1100);
    snoop(32'h0000_3000, 2'b11);
    get_cr(r);
    chk("s3_cr", 32'(r), 32'b01101);
    get_cd(8, n, lp);
    chk("s3_beats", 32'(n), 32'd4);
    chk("s3_last", 32'(lp), 32'd3);
    for (int i = 0; i < 4; i++) chk($sformatf("s3_d%0d", i), cd_got[i], 32'h1100 + 32'(i));
    wait_idle(leaks);

    // two suppliers: port0 wins, port1 drained, IDLE only after port1's last beat
    arm(0, 0, 0, 0, 5'b00001, 5'b00001, 2, 4, 32'hA000, 32'hB000);
    snoop(32'h0000_4000, 2'b11);
    get_cr(r);
    chk("s4_cr", 32'(r), 32'b00001);
    get_cd(8, n, lp);
    chk("s4_beats", 32'(n), 32'd2);
    chk("s4_last", 32'(lp), 32'd1);
    chk("s4_d0", cd_got[0], 32'hA000);
    chk("s4_d1", cd_got[1], 32'hA001);
    @(negedge clk);
    chk("s4_busy", 32'(bus.slv_resp.ac_ready), 32'd0);
    @(posedge clk); #1;
    wait_idle(leaks);
    chk("s4_leak", 32'(leaks), 32'd0);
    chk("s4_p1_drained", 32'(ph[1]), 32'd4);

    // port0 stalls AC for 10 cycles; port1's CR is still taken meanwhile
    arm(10, 0, 0, 0, 5'b00000, 5'b01000, 0, 0, 0, 0);
    snoop(32'h0000_5000, 2'b11);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("s5_p1_cr_done", 32'(ph[1]), 32'd4);
    chk("s5_p0_waiting", 32'(ph[0]), 32'd0);
    chk("s5_ac0_valid", 32'(bus.mst_reqs[0].ac_valid), 32'd1);
    chk("s5_no_up_cr", 32'(bus.slv_resp.cr_valid), 32'd0);
    @(posedge clk); #1;
    get_cr(r);
    chk("s5_cr", 32'(r), 32'b01000);

    // reset during the second data beat, then a fresh snoop
    arm(0, 0, 0, 0, 5'b00001, 5'b00000, 4, 0, 32'hC000, 32'h0);
    snoop(32'h0000_6000, 2'b01);
    get_cr(r);
    chk("s6_cr", 32'(r), 32'b00001);
    get_cd(1, n, lp);
    chk("s6_d0", cd_got[0], 32'hC000);
    rst_i = 1'b1;
    @(negedge clk);
    chk("s6_rst_ac_ready", 32'(bus.slv_resp.ac_ready), 32'd0);
    chk("s6_rst_ctl", 32'(ctl), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    arm(0, 0, 0, 1, 5'b00010, 5'b00010, 0, 0, 0, 0);
    @(negedge clk);
    chk("s6_post_idle", 32'(bus.slv_resp.ac_ready), 32'd1);
    chk("s6_post_ctl", 32'(ctl), 32'd0);
    @(posedge clk); #1;
    snoop(32'h0000_7000, 2'b11);
    get_cr(r);
    chk("s6_fresh_cr", 32'(r), 32'b00010);
    wait_idle(leaks);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
